// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified TDM master transmitter.
// Generates SCLK/LRCLK from iClk and serialises a double-buffered frame.
module i2s_tdm_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int SCLK_DIV   = 4
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iEN,
  input  logic                           iMODE,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ivDATA,
  input  logic                           iVALID,
  output logic                           oREADY,
  output logic                           oSCLK,
  output logic                           oLRCLK,
  output logic                           oSDATA,
  output logic                           oFRAME_START,
  output logic                           oUNDERRUN
);

  localparam int FRAME  = CHANNELS * SLOT_WIDTH;
  localparam int DW_ALL = CHANNELS * DATA_WIDTH;
  localparam int BW     = $clog2(FRAME);
  localparam int CW     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL
  } state_t;

  state_t              state;
  logic [CW-1:0]       divCnt;
  logic [BW-1:0]       bitCnt;
  logic [FRAME-1:0]    shiftReg;
  logic [DW_ALL-1:0]   holdData;
  logic                holdFull;
  logic                modeLj;

  logic                divWrap;
  logic                fallEdge;
  logic                lastBit;
  logic                fsEdge;
  logic                accept;
  logic                underrun;
  logic                holdFullNext;
  logic [DW_ALL-1:0]   loadData;
  logic [FRAME-1:0]    nextFrame;

  // Frame bit 0 sits in the MSB so shifting left walks the frame in order.
  function automatic logic [FRAME-1:0] packFrame(
    input logic [DW_ALL-1:0] d
  );
    logic [FRAME-1:0] f;
    f = '0;
    for (int s = 0; s < CHANNELS; s++) begin
      for (int k = 0; k < DATA_WIDTH; k++) begin
        f[FRAME-1-(s*SLOT_WIDTH+k)] =
          d[s*DATA_WIDTH+DATA_WIDTH-1-k];
      end
    end
    return f;
  endfunction

  always_comb begin
    divWrap  = divCnt == CW'(SCLK_DIV - 1);
    fallEdge = (state != IDLE) && divWrap && oSCLK;
    lastBit  = bitCnt == BW'(FRAME - 1);
    fsEdge   = iEN && ((state == IDLE) ||
               (state == RUN && fallEdge && lastBit));
    accept   = iVALID && oREADY;
    underrun = fsEdge && !holdFull && !accept;
    loadData = holdFull ? holdData :
               (accept ? ivDATA : '0);
    holdFullNext = fsEdge ? 1'b0 : (holdFull || accept);
    nextFrame = packFrame(loadData);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= IDLE;
      divCnt       <= '0;
      bitCnt       <= '0;
      shiftReg     <= '0;
      holdData     <= '0;
      holdFull     <= 1'b0;
      modeLj       <= 1'b0;
      oREADY       <= 1'b0;
      oSCLK        <= 1'b0;
      oLRCLK       <= 1'b0;
      oSDATA       <= 1'b0;
      oFRAME_START <= 1'b0;
      oUNDERRUN    <= 1'b0;
    end else begin
      holdFull     <= holdFullNext;
      oREADY       <= !holdFullNext;
      oFRAME_START <= fsEdge;
      oUNDERRUN    <= underrun;
      if (accept && !fsEdge) holdData <= ivDATA;
      if (fsEdge) begin
        shiftReg <= nextFrame;
        modeLj   <= iMODE;
      end
      unique case (state)
        IDLE: begin
          divCnt <= '0;
          oSCLK  <= 1'b0;
          bitCnt <= '0;
          oLRCLK <= 1'b0;
          oSDATA <= (iEN && iMODE) ? nextFrame[FRAME-1] : 1'b0;
          if (iEN) state <= RUN;
        end
        RUN: begin
          divCnt <= divWrap ? '0 : divCnt + 1'b1;
          if (divWrap) oSCLK <= !oSCLK;
          if (fallEdge) begin
            if (!lastBit) begin
              bitCnt   <= bitCnt + 1'b1;
              oLRCLK   <= bitCnt >= BW'(FRAME/2 - 1);
              shiftReg <= shiftReg << 1;
              oSDATA   <= modeLj ? shiftReg[FRAME-2]
                                 : shiftReg[FRAME-1];
            end else if (iEN) begin
              bitCnt <= '0;
              oLRCLK <= 1'b0;
              oSDATA <= iMODE ? nextFrame[FRAME-1]
                              : shiftReg[FRAME-1];
            end else if (!modeLj) begin
              // I2S owes one more SCLK for the delayed last bit.
              state  <= TAIL;
              bitCnt <= '0;
              oLRCLK <= 1'b0;
              oSDATA <= shiftReg[FRAME-1];
            end else begin
              state  <= IDLE;
              divCnt <= '0;
              bitCnt <= '0;
              oLRCLK <= 1'b0;
              oSDATA <= 1'b0;
            end
          end
        end
        TAIL: begin
          divCnt <= divWrap ? '0 : divCnt + 1'b1;
          if (divWrap) oSCLK <= !oSCLK;
          if (fallEdge) begin
            state  <= IDLE;
            divCnt <= '0;
            oSDATA <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
